// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display path: pattern type,
// the hex-to-segment table and the scan decoder state encoding.
package seg7_pkg;

    // Active-low segment pattern, bit 6 = a .. bit 0 = g.
    typedef logic [6:0] seg7_t;

    // Pattern for each hex digit 0..F. The encoder drives from this
    // same table, so the decoder is its exact inverse.
    localparam seg7_t SEG7_TABLE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        COMMIT = 2'd2,
        ERR    = 2'd3
    } scan_state_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational inverse of SEG7_TABLE: segment pattern to hex nibble.
// Patterns not in the table report invalid and return nibble 0.
module seg7_to_hex
    import seg7_pkg::*;
(
    input  seg7_t      seg,
    output logic [3:0] nibble,
    output logic       invalid
);

    // Search the table; an unmatched pattern keeps the invalid default.
    always_comb begin
        nibble  = 4'd0;
        invalid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG7_TABLE[i]) begin
                nibble  = 4'(i);
                invalid = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Monitor for the multiplexed 7-segment bus. Each lit digit's pattern is
// decoded once it has been stable long enough; when every digit of a frame
// has been captured the whole word is committed to value.
//
// Output signalling: value_valid is a one-cycle pulse in the same cycle
// that value/digit_err take their new contents; frame_err is a one-cycle
// pulse for a discarded frame. There is no backpressure, and the two pulses
// are never high together. The FSM state is held in 'state' for probing.
module seven_seg_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic [6:0]              seg,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic                    value_valid,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    frame_err
);

    localparam int            CW  = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] S_C = CW'(STABLE_CYCLES);

    logic [NUM_DIGITS-1:0]   an_s1, an_s2, an_prev;
    seg7_t                   seg_s1, seg_s2, seg_prev;
    logic [CW-1:0]           cnt, run_now;
    logic                    same, reach;
    logic [NUM_DIGITS-1:0]   lit;
    logic                    is_blank, is_one_hot, is_multi;
    logic [3:0]              nibble;
    logic                    invalid;
    scan_state_t             state, state_next;
    logic                    cap_en;
    logic [NUM_DIGITS-1:0]   base, cap_mask, captured, captured_next;
    logic [4*NUM_DIGITS-1:0] shadow_val, shadow_val_next;
    logic [NUM_DIGITS-1:0]   shadow_err, shadow_err_next;

    // Two-flop synchronizers plus the previous synced sample for change detect.
    // Reset to the blanked bus so the first real sample reads as a change.
    always_ff @(posedge clk) begin
        if (reset) begin
            an_s1    <= '1;
            an_s2    <= '1;
            an_prev  <= '1;
            seg_s1   <= '1;
            seg_s2   <= '1;
            seg_prev <= '1;
        end else begin
            an_s1    <= an;
            an_s2    <= an_s1;
            an_prev  <= an_s2;
            seg_s1   <= seg;
            seg_s2   <= seg_s1;
            seg_prev <= seg_s2;
        end
    end

    // run_now is the number of consecutive identical samples including the
    // current one; reach fires only on the cycle the run first hits the
    // threshold, so a digit held on across a commit is not captured again.
    always_comb begin
        same    = (an_s2 == an_prev) && (seg_s2 == seg_prev);
        run_now = CW'(1);
        if (same) begin
            run_now = (cnt == S_C) ? S_C : cnt + CW'(1);
        end
        reach = (run_now == S_C) && !(same && (cnt == S_C));
    end

    // Saturating stability counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= run_now;
        end
    end

    // Classify the synced anode code.
    always_comb begin
        lit        = ~an_s2;
        is_blank   = ~|lit;
        is_one_hot = $onehot(lit);
        is_multi   = !is_blank && !is_one_hot;
    end

    seg7_to_hex u_seg7_to_hex (
        .seg     (seg_s2),
        .nibble  (nibble),
        .invalid (invalid)
    );

    // Next state, capture mask and shadow update. An illegal anode code
    // blocks capture in the same cycle.
    always_comb begin
        state_next      = state;
        cap_en          = 1'b0;
        base            = captured;
        case (state)
            IDLE: begin
                if (is_one_hot) begin
                    state_next = TRACK;
                    cap_en     = 1'b1;
                end
            end
            TRACK: begin
                if (is_multi) state_next = ERR;
                else          cap_en     = 1'b1;
            end
            COMMIT: begin
                base = '0;
                if (is_multi) begin
                    state_next = ERR;
                end else begin
                    state_next = TRACK;
                    cap_en     = 1'b1;
                end
            end
            ERR: begin
                base       = '0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        cap_mask      = (cap_en && reach) ? (lit & ~base) : '0;
        captured_next = base | cap_mask;
        if (state_next == ERR) begin
            captured_next = '0;
        end else if (cap_en && (&captured_next)) begin
            state_next = COMMIT;
        end

        shadow_val_next = shadow_val;
        shadow_err_next = shadow_err;
        if (state == ERR) begin
            shadow_val_next = '0;
            shadow_err_next = '0;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cap_mask[i]) begin
                shadow_val_next[4*i +: 4] = nibble;
                shadow_err_next[i]        = invalid;
            end
        end
    end

    // State, capture mask and shadow registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            captured   <= '0;
            shadow_val <= '0;
            shadow_err <= '0;
        end else begin
            state      <= state_next;
            captured   <= captured_next;
            shadow_val <= shadow_val_next;
            shadow_err <= shadow_err_next;
        end
    end

    // Outputs are registered on entry to COMMIT/ERR so they coincide with
    // those one-cycle states.
    always_ff @(posedge clk) begin
        if (reset) begin
            value       <= '0;
            digit_err   <= '0;
            value_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            value_valid <= (state_next == COMMIT);
            frame_err   <= (state_next == ERR);
            if (state_next == COMMIT) begin
                value     <= shadow_val_next;
                digit_err <= shadow_err_next;
            end
        end
    end

endmodule
